xgriscv_mem_arb: RTL
====================

# xgriscv_mem_arb

Parametrised multi-port memory subsystem for the next-generation xgriscv core. A round-robin arbiter shares one word-organised single-port RAM among NPORTS requesters (instruction fetch, load/store, future DMA/debug) through a valid/ready request and valid response handshake. It supports configurable wait states and byte/halfword/word access with sign or zero extension. It sits between the core's fetch and LSU ports and replaces the separate fixed-size instruction and data memories.

## Interface
- NPORTS, 2, number of requester channels (1..8); port 0 is fetch by convention
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two)
- WAIT_CYCLES, 0, extra access wait states (0..15)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NPORTS  request present, per port
- req_ready  out  NPORTS  request accepted this cycle, per port
- req_we  in  NPORTS  1 = store, 0 = load
- req_addr  in  32*NPORTS  byte address, port i at [32i+31:32i]
- req_type  in  3*NPORTS  RW_type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  in  32*NPORTS  store data, right-aligned
- rsp_valid  out  NPORTS  one-cycle response pulse, per port
- rsp_rdata  out  32*NPORTS  extended load data; 0 for stores and errors
- rsp_err  out  NPORTS  misaligned, out-of-range or illegal type

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid, select the winner g by round-robin. The search starts at last_grant+1 and wraps.
  - req_ready[g]=1 combinationally in IDLE only. All other req_ready are 0.
  - On the edge, capture we/addr/type/wdata and g, and set last_grant=g.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: down-counter loaded with WAIT_CYCLES-1. Go to RESP when it reads 0.
- RAM access is committed on the edge entering RESP. A store writes only the enabled bytes. A load registers the word.
- RESP: rsp_valid[g]=1 and rsp_rdata/rsp_err driven for exactly one cycle, then IDLE. There is no response backpressure; requesters must sample it.
- Byte lane = addr[1:0]. Halfword uses addr[1].
  - Load B/H sign-extends; BU/HU zero-extends; W is raw.
  - Store B replicates into the lane with 1-bit enable. Store H uses a 2-bit enable. Store W uses 4'b1111.
- Error cases:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
  - type 011/110/111, or a store with type 1xx.
  - Response on error: rsp_err=1, rdata=0, no RAM write. Still one response pulse.
- RAM contents are not reset. Only control state is reset.

## Timing
- Request accepted at edge T gives rsp_valid high during cycle T+1+WAIT_CYCLES.
- The next acceptance is possible at the edge ending the RESP cycle.
- Peak throughput: one access per 2+WAIT_CYCLES cycles.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - state=IDLE, last_grant=NPORTS-1, so port 0 wins first.
- Reset asserted mid-transaction: immediately IDLE, pending response dropped. The store is not performed if reset precedes the commit edge.
- A requester whose req_valid drops before it is granted is simply skipped. A single active requester is served back-to-back.

## Structure
- Package xgriscv_mem_pkg holds:
  - RW_type localparams (RW_B, RW_H, RW_W, RW_BU, RW_HU).
  - The state enum.
  - Functions for byte-enable generation and load extension.
- Sub-module xgriscv_rr_arbiter(NPORTS): req vector plus last_grant in, one-hot grant plus index out, purely combinational.
- RAM is an inferred reg array of DEPTH_WORDS x 32 with a 4-bit byte write enable, kept inside the top.

## Test plan
- Reset then a single port 1 store W 0xDEADBEEF at 0x10, then a load W at 0x10. Required: rsp_valid[1] at T+1 with rdata=0 (WAIT_CYCLES=0), then rdata=0xDEADBEEF.
- Store B 0x80 at 0x13, then load B and BU at 0x13. Required: 0xFFFFFF80 and 0x00000080. Word 0x10 reads 0x80ADBEEF.
- Both ports request continuously. Required grants alternate 0,1,0,1, with port 0 first after reset and no starvation over 100 requests.
- Load H at 0x11, store W at 0x4002 (DEPTH_WORDS=1024), and type 011. Required for each: rsp_err=1, rdata=0, and the target word unchanged.
- WAIT_CYCLES=3: accept at T gives rsp_valid at T+4. Reset asserted at T+2 of a store gives no response and the RAM word unchanged.

Source files
------------

// File: rtl/xgriscv_mem_pkg.sv
// Shared definitions for the xgriscv multi-port memory subsystem: access
// type encodings, the controller state type and the byte-lane helpers used
// on both the store and the load path.
package xgriscv_mem_pkg;

  // RW_type encodings carried on req_type
  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Per-byte write enable for a store of the given type at the given lane.
  function automatic logic [3:0] byte_enable(input logic [2:0] rw_type,
                                             input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (rw_type)
      RW_B, RW_BU: be = 4'b0001 << lane;
      RW_H, RW_HU: be = lane[1] ? 4'b1100 : 4'b0011;
      RW_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across every lane it could land in,
  // so the byte enables alone pick the destination bytes.
  function automatic logic [31:0] store_align(input logic [31:0] wdata,
                                              input logic [2:0]  rw_type);
    logic [31:0] d;
    d = wdata;
    case (rw_type)
      RW_B, RW_BU: d = {4{wdata[7:0]}};
      RW_H, RW_HU: d = {2{wdata[15:0]}};
      default:     d = wdata;
    endcase
    return d;
  endfunction

  // Pick the addressed byte/halfword out of a RAM word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  rw_type,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (rw_type)
      RW_B:    r = {{24{b[7]}}, b};
      RW_BU:   r = {24'h000000, b};
      RW_H:    r = {{16{h[15]}}, h};
      RW_HU:   r = {16'h0000, h};
      RW_W:    r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Encodings 011/110/111 are undefined; sign/zero choice is meaningless
  // for a store, so stores accept only the 0xx forms.
  function automatic logic type_legal(input logic [2:0] rw_type,
                                      input logic       we);
    logic ok;
    case (rw_type)
      RW_B, RW_H, RW_W: ok = 1'b1;
      RW_BU, RW_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment check for halfword and word accesses.
  function automatic logic misaligned(input logic [2:0] rw_type,
                                      input logic [1:0] lane);
    logic bad;
    case (rw_type)
      RW_H, RW_HU: bad = lane[0];
      RW_W:        bad = (lane != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/xgriscv_rr_arbiter.sv
// Purely combinational round-robin arbiter. The search for a winner starts
// one past the previously granted port and wraps, so every requester is
// reached within NPORTS grants.
module xgriscv_rr_arbiter #(
  parameter int NPORTS = 2,
  parameter int IDXW   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDXW-1:0]   last_grant,
  output logic [NPORTS-1:0] grant,
  output logic [IDXW-1:0]   grant_idx,
  output logic              grant_valid
);

  logic found;

  // Scan ports in rotated priority order and take the first requester.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= NPORTS; k++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (!found && req[i] && (((int'(last_grant) + k) % NPORTS) == i)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDXW'(i);
        end
      end
    end
    grant_valid = found;
  end

endmodule

// File: rtl/xgriscv_mem_arb.sv
// Multi-port memory subsystem: a round-robin arbiter shares one word-wide
// single-port RAM among NPORTS requesters. Each access is accepted in IDLE,
// optionally waits WAIT_CYCLES, commits to the RAM on the edge into RESP and
// returns a one-cycle response pulse to the granted port.
module xgriscv_mem_arb
  import xgriscv_mem_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORTS-1:0]      req_valid,
  output logic [NPORTS-1:0]      req_ready,
  input  logic [NPORTS-1:0]      req_we,
  input  logic [32*NPORTS-1:0]   req_addr,
  input  logic [3*NPORTS-1:0]    req_type,
  input  logic [32*NPORTS-1:0]   req_wdata,
  output logic [NPORTS-1:0]      rsp_valid,
  output logic [32*NPORTS-1:0]   rsp_rdata,
  output logic [NPORTS-1:0]      rsp_err
);

  localparam int IDXW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [IDXW-1:0] LAST_GRANT_RST = IDXW'(NPORTS - 1);

  // Control state
  state_e            state_q, state_d;
  logic [IDXW-1:0]   last_grant_q, last_grant_d;
  logic [IDXW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  // Captured request
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic [31:0]       wdata_q, wdata_d;
  // Registered response
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Arbiter results and the winning request's fields
  logic [NPORTS-1:0] arb_grant;
  logic [IDXW-1:0]   arb_idx;
  logic              arb_any;
  logic              accept;
  logic              win_we;
  logic [31:0]       win_addr;
  logic [2:0]        win_type;
  logic [31:0]       win_wdata;

  // Access being committed (winner when committing straight from IDLE)
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [2:0]        acc_type;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic [AW-1:0]     acc_index;
  logic              commit;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0]       mem [DEPTH_WORDS];

  xgriscv_rr_arbiter #(
    .NPORTS (NPORTS),
    .IDXW   (IDXW)
  ) u_arb (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_any)
  );

  // Only IDLE accepts, and nothing is accepted while reset is held.
  assign accept = (state_q == ST_IDLE) && arb_any && !reset;

  // Multiplex the granted port's request fields.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = 32'h0;
    win_type  = 3'b000;
    win_wdata = 32'h0;
    for (int i = 0; i < NPORTS; i++) begin
      if (arb_grant[i]) begin
        win_we    = req_we[i];
        win_addr  = req_addr[32*i +: 32];
        win_type  = req_type[3*i +: 3];
        win_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  // Choose the access to commit and classify it.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = win_we;
      acc_addr  = win_addr;
      acc_type  = win_type;
      acc_wdata = win_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_type  = type_q;
      acc_wdata = wdata_q;
    end
    acc_err   = !type_legal(acc_type, acc_we) ||
                misaligned(acc_type, acc_addr[1:0]) ||
                ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    acc_index = acc_addr[AW+1:2];
    ram_be    = byte_enable(acc_type, acc_addr[1:0]);
    ram_wdata = store_align(acc_wdata, acc_type);
    ram_rdata = mem[acc_index];
  end

  // Next-state logic: arbitration, wait countdown, commit and response.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_idx_d    = gnt_idx_q;
    wait_cnt_d   = wait_cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    type_d       = type_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    commit       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d         = win_we;
          addr_d       = win_addr;
          type_d       = win_type;
          wdata_d      = win_wdata;
          gnt_idx_d    = arb_idx;
          last_grant_d = arb_idx;
          if (WAIT_CYCLES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'h0
                                    : load_extend(ram_rdata, acc_type, acc_addr[1:0]);
    end
  end

  assign ram_we = commit && acc_we && !acc_err;

  // Control and response registers; a reset drops any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers update with non-blocking assignments so every
      // flop samples the pre-edge values regardless of statement order.
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_GRANT_RST;
      gnt_idx_q    <= '0;
      wait_cnt_q   <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      type_q       <= 3'b000;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_idx_q    <= gnt_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      type_q       <= type_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Byte-enabled RAM write on the commit edge.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately left out of reset so it maps onto
    // a plain memory macro; only control state is reset.
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) begin
          mem[acc_index][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Handshake and response outputs.
  always_comb begin
    req_ready = accept ? arb_grant : '0;
    rsp_valid = '0;
    rsp_err   = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if ((state_q == ST_RESP) && (gnt_idx_q == IDXW'(i))) begin
        rsp_valid[i]          = 1'b1;
        rsp_err[i]            = err_q;
        rsp_rdata[32*i +: 32] = rdata_q;
      end
    end
  end

endmodule
